mi_sequencer: RTL and testbench

//  Consumes 33-bit microwords from the microinstruction ROM and sequences execution.

---
 rtl/mi_seq_if.sv | 46 ++++
 rtl/mi_sequencer.sv | 124 ++++++++++++
 tb/tb_mi_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mi_seq_if.sv
// Signal bundle between mi_sequencer and instruction memory, microcode ROM, datapath and data memory.
// err_tmo exists only when MEM_TIMEOUT_EN is defined.
interface mi_seq_if #(parameter int PC_W = 11);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [21:0]     imem_data;
    logic [21:0]     ir_out;
    logic [32:0]     mi_in;
    logic            flag_z;
    logic            flag_cy;
    logic            exec_stb;
    logic [3:0]      alu_op;
    logic [1:0]      sh_op;
    logic            kmx;
    logic [5:0]      bus_b;
    logic [5:0]      bus_c;
    logic [6:0]      t_word;
    logic [4:0]      bus_a;
    logic            dmem_rd;
    logic            dmem_wr;
    logic            dmem_ack;
    logic [PC_W-1:0] pc_out;
    logic            busy;
`ifdef MEM_TIMEOUT_EN
    logic            err_tmo;
`endif

    modport master (
`ifdef MEM_TIMEOUT_EN
        output err_tmo,
`endif
        output imem_req, imem_addr, ir_out, exec_stb, alu_op, sh_op, kmx,
               bus_b, bus_c, t_word, bus_a, dmem_rd, dmem_wr, pc_out, busy,
        input  imem_ack, imem_data, mi_in, flag_z, flag_cy, dmem_ack
    );

    modport slave (
`ifdef MEM_TIMEOUT_EN
        input  err_tmo,
`endif
        input  imem_req, imem_addr, ir_out, exec_stb, alu_op, sh_op, kmx,
               bus_b, bus_c, t_word, bus_a, dmem_rd, dmem_wr, pc_out, busy,
        output imem_ack, imem_data, mi_in, flag_z, flag_cy, dmem_ack
    );
endinterface

// File: rtl/mi_sequencer.sv
// Microword sequencer: fetch, decode through the ROM, execute strobe, data-memory handshake, branch/PC update.
// Optional MEM_TIMEOUT_EN adds a bounded data-memory wait with sticky err_tmo.
module mi_sequencer #(
    parameter int              PC_W   = 11,
    parameter logic [PC_W-1:0] RST_PC = '0
`ifdef MEM_TIMEOUT_EN
    , parameter int            TMO_CYC = 255
`endif
) (
    input  logic      clk,
    input  logic      reset,
    mi_seq_if.master  bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, NEXT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [21:0]     ir;
    logic [32:0]     mi;
    logic            imem_req;
    logic            exec_stb;
    logic            dmem_rd;
    logic            dmem_wr;
    logic            cond;
    logic            taken;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
    logic [7:0] wait_cnt;
    logic       err_tmo;
    assign bus.err_tmo = err_tmo;
`endif

    // t_word = mi[11:5]: bit 6 enables the branch, bit 4 picks CY, bit 0 picks Z; jne inverts.
    always_comb begin
        cond  = mi[9] ? bus.flag_cy : (mi[5] ? bus.flag_z : 1'b1);
        taken = mi[11] && (cond ^ (ir[21:19] == 3'b110));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RST_PC;
            ir       <= '0;
            mi       <= '0;
            imem_req <= 1'b0;
            exec_stb <= 1'b0;
            dmem_rd  <= 1'b0;
            dmem_wr  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
            err_tmo  <= 1'b0;
`endif
        end else begin
            exec_stb <= 1'b0;
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir       <= bus.imem_data;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    mi       <= bus.mi_in;
                    exec_stb <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    // A read wins when the microword asks for both.
                    if (mi[25] || mi[24]) begin
                        dmem_rd <= mi[25];
                        dmem_wr <= ~mi[25];
                        state   <= MEM;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        state <= NEXT;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_rd <= 1'b0;
                        dmem_wr <= 1'b0;
                        state   <= NEXT;
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt == TMO_LAST) begin
                        dmem_rd <= 1'b0;
                        dmem_wr <= 1'b0;
                        err_tmo <= 1'b1;
                        state   <= NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                NEXT: begin
                    pc    <= taken ? ir[PC_W-1:0] : pc + PC_W'(1);
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc;
    assign bus.pc_out    = pc;
    assign bus.ir_out    = ir;
    assign bus.exec_stb  = exec_stb;
    assign bus.dmem_rd   = dmem_rd;
    assign bus.dmem_wr   = dmem_wr;
    assign bus.busy      = !(state == FETCH && !imem_req);
    assign bus.alu_op    = mi[32:29];
    assign bus.sh_op     = mi[28:27];
    assign bus.kmx       = mi[26];
    assign bus.bus_b     = mi[23:18];
    assign bus.bus_c     = mi[17:12];
    assign bus.t_word    = mi[11:5];
    assign bus.bus_a     = mi[4:0];
endmodule

// File: tb/tb_mi_sequencer.sv
// Testbench for mi_sequencer: per-cycle expected trace built from instruction-level rules, plus directed literals.
module tb_mi_sequencer;
    localparam int PC_W = 11;

    typedef struct packed {
        logic [4:0]      ctrl;     // {imem_req, busy, exec_stb, dmem_rd, dmem_wr}
        logic [PC_W-1:0] pc;
        logic [21:0]     ir;
        logic [30:0]     fields;   // {alu_op, sh_op, kmx, bus_b, bus_c, t_word, bus_a}
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mi_seq_if #(.PC_W(PC_W)) sif ();

    mi_sequencer #(
        .PC_W(PC_W),
        .RST_PC(11'h000)
`ifdef MEM_TIMEOUT_EN
        , .TMO_CYC(10)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(sif)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          rd_cnt = 0;
    int          exec_cnt = 0;
    int          m_pc;
    logic [21:0] m_ir;
    logic [30:0] m_fields;

    localparam logic [32:0] ADW_MI = {4'b0101, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 6'd3, 7'd0, 5'd5};
    localparam logic [32:0] JZE_MI = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 7'b1000001, 5'd0};
    localparam logic [32:0] JMP_MI = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 7'b1000000, 5'd0};
    localparam logic [32:0] MOM_MI = {4'b0010, 2'b00, 1'b0, 1'b1, 1'b0, 6'd7, 6'd9, 7'd0, 5'd2};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Runs one instruction: d extra fetch-wait cycles, w memory cycles, z/cy presented in NEXT.
    task automatic applyStimulus(input logic [21:0] instr, input logic [32:0] mi, input int d,
                                 input int w, input bit ack_en, input logic z, input logic cy);
        exp_t       e;
        logic       mr, mw, cond;
        logic [6:0] t;
        int         wn, n, mem_idx, nxt;
        mr = mi[25];
        mw = mi[24] && !mi[25];
        wn = (mr || mw) ? w : 0;
        n  = d + wn + 5;
        t  = mi[11:5];

        e.pc = m_pc[PC_W-1:0]; e.ir = m_ir; e.fields = m_fields;
        e.ctrl = 5'b00000; exp_q.push_back(e);
        e.ctrl = 5'b11000; repeat (d + 1) exp_q.push_back(e);
        m_ir = instr; e.ir = instr;
        e.ctrl = 5'b01000; exp_q.push_back(e);
        m_fields = {mi[32:26], mi[23:0]}; e.fields = m_fields;
        e.ctrl = 5'b01100; exp_q.push_back(e);
        e.ctrl = {3'b010, mr, mw}; repeat (wn) exp_q.push_back(e);
        e.ctrl = 5'b01000; exp_q.push_back(e);

        cond = t[4] ? cy : (t[0] ? z : 1'b1);
        if (instr[21:19] == 3'b110) cond = !cond;
        nxt = (t[6] && cond) ? int'(instr[PC_W-1:0]) : (m_pc + 1) % (1 << PC_W);

        for (int c = 0; c < n; c++) begin
            sif.imem_ack  = (c == d + 1);
            sif.imem_data = (c == d + 1) ? instr : 22'($urandom);
            sif.mi_in     = (c == d + 2) ? mi : 33'({$urandom, $urandom});
            mem_idx       = c - (d + 4);
            sif.dmem_ack  = (mem_idx >= 0 && mem_idx < wn) ? (ack_en && mem_idx == wn - 1) : 1'($urandom);
            sif.flag_z    = (c == n - 1) ? z : 1'($urandom);
            sif.flag_cy   = (c == n - 1) ? cy : 1'($urandom);
            @(posedge clk); #2;
        end
        m_pc = nxt;
    endtask

    always @(negedge clk) begin
        if (sif.dmem_rd) rd_cnt++;
        if (sif.exec_stb) exec_cnt++;
    end

    // Every cycle with a planned expectation is compared against the model.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("ctrl{req,busy,exec,rd,wr}",
                            64'({sif.imem_req, sif.busy, sif.exec_stb, sif.dmem_rd, sif.dmem_wr}), 64'(e.ctrl));
                checkOutput("pc_out", 64'(sif.pc_out), 64'(e.pc));
                checkOutput("imem_addr", 64'(sif.imem_addr), 64'(e.pc));
                checkOutput("ir_out", 64'(sif.ir_out), 64'(e.ir));
                checkOutput("fields", 64'({sif.alu_op, sif.sh_op, sif.kmx, sif.bus_b, sif.bus_c,
                                           sif.t_word, sif.bus_a}), 64'(e.fields));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int          r0, x0, pc0;
        logic [21:0] instr;
        logic [32:0] mi;
        reset = 1'b1;
        sif.imem_ack = 1'b0; sif.imem_data = '0; sif.mi_in = '0;
        sif.flag_z = 1'b0; sif.flag_cy = 1'b0; sif.dmem_ack = 1'b0;
        m_pc = 0; m_ir = '0; m_fields = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        checkOutput("reset imem_addr", 64'(sif.imem_addr), 64'd0);
        checkOutput("reset outputs", 64'({sif.imem_req, sif.busy, sif.exec_stb, sif.dmem_rd, sif.dmem_wr,
                                          sif.ir_out, sif.alu_op, sif.bus_c, sif.bus_a, sif.t_word}), 64'd0);
`ifdef MEM_TIMEOUT_EN
        checkOutput("reset err_tmo", 64'(sif.err_tmo), 64'd0);
`endif

        x0 = exec_cnt;
        applyStimulus(22'h180065, ADW_MI, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("adw pc", 64'(sif.pc_out), 64'h001);
        checkOutput("adw exec_stb count", 64'(exec_cnt - x0), 64'd1);
        checkOutput("adw bus_c", 64'(sif.bus_c), 64'd3);
        checkOutput("adw bus_a", 64'(sif.bus_a), 64'd5);

        applyStimulus(22'h08002A, JZE_MI, 1, 0, 1'b1, 1'b1, 1'b0);
        checkOutput("jze taken pc", 64'(sif.pc_out), 64'h02A);
        applyStimulus(22'h08002A, JZE_MI, 0, 0, 1'b1, 1'b0, 1'b1);
        checkOutput("jze not taken pc", 64'(sif.pc_out), 64'h02B);
        applyStimulus(22'h30002A, JZE_MI, 2, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("jne taken pc", 64'(sif.pc_out), 64'h02A);

        r0 = rd_cnt;
        applyStimulus(22'h200000, MOM_MI, 0, 4, 1'b1, 1'b1, 1'b1);
        checkOutput("mom dmem_rd cycles", 64'(rd_cnt - r0), 64'd4);
        checkOutput("mom pc", 64'(sif.pc_out), 64'h02B);

        applyStimulus(22'h0007FF, JMP_MI, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("jmp max pc", 64'(sif.pc_out), 64'h7FF);
        applyStimulus(22'h180065, ADW_MI, 0, 0, 1'b1, 1'b1, 1'b1);
        checkOutput("pc wrap", 64'(sif.pc_out), 64'h000);

        for (int i = 0; i < 60; i++) begin
            instr = 22'($urandom);
            if ($urandom_range(0, 3) == 0) instr[21:19] = 3'b110;
            mi = 33'({$urandom, $urandom});
            applyStimulus(instr, mi, $urandom_range(0, 3), $urandom_range(1, 5), 1'b1,
                          1'($urandom), 1'($urandom));
        end

        // Abort a read mid-wait with reset.
        applyStimulus(22'h000155, JMP_MI, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("jmp 0x155 pc", 64'(sif.pc_out), 64'h155);
        sif.dmem_ack = 1'b0;
        sif.imem_ack = 1'b0;
        @(posedge clk); #2;
        sif.imem_ack = 1'b1; sif.imem_data = 22'h200000;
        @(posedge clk); #2;
        sif.imem_ack = 1'b0; sif.mi_in = MOM_MI;
        @(posedge clk); #2;
        @(posedge clk); #2;
        checkOutput("mid-mem dmem_rd", 64'(sif.dmem_rd), 64'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        checkOutput("reset mid-mem dmem_rd", 64'(sif.dmem_rd), 64'd0);
        checkOutput("reset mid-mem pc", 64'(sif.pc_out), 64'h000);
        checkOutput("reset mid-mem busy", 64'(sif.busy), 64'd0);
        m_pc = 0; m_ir = '0; m_fields = '0;
        applyStimulus(22'h180065, ADW_MI, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("restart pc", 64'(sif.pc_out), 64'h001);

`ifdef MEM_TIMEOUT_EN
        r0 = rd_cnt;
        pc0 = m_pc;
        applyStimulus(22'h200000, MOM_MI, 0, 10, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout dmem_rd cycles", 64'(rd_cnt - r0), 64'd10);
        checkOutput("timeout err_tmo", 64'(sif.err_tmo), 64'd1);
        checkOutput("timeout pc", 64'(sif.pc_out), 64'(pc0 + 1));
        applyStimulus(22'h180065, ADW_MI, 1, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("err_tmo sticky", 64'(sif.err_tmo), 64'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        checkOutput("err_tmo cleared", 64'(sif.err_tmo), 64'd0);
`else
        pc0 = 0;
`endif

        checkOutput("queue drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
